// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: decoder data port, fetch port and the shared external memory bus.
// The arbiter uses the slave modport; the surrounding system uses master.
interface mem_arbiter_if;
  logic        ram_read;
  logic        ram_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        mem_busy;
  logic        mem_ready;

  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ready;

  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;
  logic        bus_err;

  modport slave (
    input  ram_read, ram_write, d_addr, d_wdata, if_req, if_addr, ext_rdata, ext_ack,
    output d_rdata, mem_busy, mem_ready, if_rdata, if_ready,
           ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );

  modport master (
    output ram_read, ram_write, d_addr, d_wdata, if_req, if_addr, ext_rdata, ext_ack,
    input  d_rdata, mem_busy, mem_ready, if_rdata, if_ready,
           ext_req, ext_we, ext_addr, ext_wdata, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates decoder data accesses and instruction fetches onto one external memory bus.
// Optional access timeout with bus_err reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, D_ACC, F_ACC, D_DONE, F_DONE} state_t;

  state_t      r_state;
  logic        r_pend_valid;
  logic        r_pend_we;
  logic [15:0] r_pend_addr;
  logic [15:0] r_pend_wdata;
  logic        r_last_data;
  logic        r_ext_req;
  logic        r_ext_we;
  logic [15:0] r_ext_addr;
  logic [15:0] r_ext_wdata;
  logic [15:0] r_d_rdata;
  logic [15:0] r_if_rdata;
  logic        r_mem_busy;
  logic        r_mem_ready;
  logic        r_if_ready;

  logic        w_capture;
  logic        w_grant_data;
  logic        w_timeout;

`ifdef MEM_TIMEOUT_EN
  logic [7:0]  r_tmo;
  logic        r_bus_err;
  assign w_timeout   = (r_tmo == 8'hFF) && !bus.ext_ack;
  assign bus.bus_err = r_bus_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  assign w_capture    = (bus.ram_read | bus.ram_write) & ~r_pend_valid;
  // Data wins unless it also won last time and a fetch is waiting.
  assign w_grant_data = r_pend_valid & ~(r_last_data & bus.if_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pend_valid <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_last_data  <= 1'b0;
      r_ext_req    <= 1'b0;
      r_ext_we     <= 1'b0;
      r_ext_addr   <= '0;
      r_ext_wdata  <= '0;
      r_d_rdata    <= '0;
      r_if_rdata   <= '0;
      r_mem_busy   <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_if_ready   <= 1'b0;
    end else begin
      // The slot stays occupied until its access completes, so a held request is not re-issued.
      if (w_capture) begin
        r_pend_valid <= 1'b1;
        r_pend_we    <= bus.ram_write;
        r_pend_addr  <= bus.d_addr;
        r_pend_wdata <= bus.d_wdata;
        r_mem_busy   <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_grant_data) begin
            r_state     <= D_ACC;
            r_last_data <= 1'b1;
            r_ext_req   <= 1'b1;
            r_ext_we    <= r_pend_we;
            r_ext_addr  <= r_pend_addr;
            r_ext_wdata <= r_pend_we ? r_pend_wdata : '0;
          end else if (bus.if_req) begin
            r_state     <= F_ACC;
            r_last_data <= 1'b0;
            r_ext_req   <= 1'b1;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= bus.if_addr;
            r_ext_wdata <= '0;
          end
        end
        D_ACC: begin
          if (bus.ext_ack || w_timeout) begin
            r_ext_req    <= 1'b0;
            r_ext_we     <= 1'b0;
            r_pend_valid <= 1'b0;
            r_mem_busy   <= 1'b0;
            if (r_ext_we) begin
              r_state <= IDLE;
            end else begin
              r_state     <= D_DONE;
              r_mem_ready <= 1'b1;
              r_d_rdata   <= bus.ext_ack ? bus.ext_rdata : '1;
            end
          end
        end
        F_ACC: begin
          if (bus.ext_ack || w_timeout) begin
            r_ext_req  <= 1'b0;
            r_state    <= F_DONE;
            r_if_ready <= 1'b1;
            r_if_rdata <= bus.ext_ack ? bus.ext_rdata : '1;
          end
        end
        D_DONE: begin
          r_mem_ready <= 1'b0;
          r_state     <= IDLE;
        end
        F_DONE: begin
          r_if_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Counter rests at zero outside an access, so it starts from zero on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if ((r_state == D_ACC || r_state == F_ACC) && !bus.ext_ack) begin
        if (r_tmo == 8'hFF) begin
          r_bus_err <= 1'b1;
          r_tmo     <= '0;
        end else begin
          r_tmo <= r_tmo + 8'd1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end
`endif

  assign bus.ext_req   = r_ext_req;
  assign bus.ext_we    = r_ext_we;
  assign bus.ext_addr  = r_ext_addr;
  assign bus.ext_wdata = r_ext_wdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_busy  = r_mem_busy;
  assign bus.mem_ready = r_mem_ready;
  assign bus.if_ready  = r_if_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, read, write, contention, fetch, mid-access reset.
// A negedge memory responder acks after ack_wait cycles with data ext_addr ^ rd_xor.
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   ack_wait;
  logic ack_force;
  logic [15:0] rd_xor;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt         = 0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_force) begin
        bus.ext_ack = 1'b1;
        cnt = 0;
      end else if (bus.ext_req) begin
        if (cnt >= ack_wait) begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = bus.ext_addr ^ rd_xor;
          cnt = 0;
        end else begin
          bus.ext_ack = 1'b0;
          cnt++;
        end
      end else begin
        bus.ext_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n, req_n, gn, busy_low;
    logic [15:0] a, wd, g0, g1, ifd;
    logic w, got, ready_seen, we_seen, prev_req;

    n_checks = 0;
    n_pass   = 0;
    ack_wait = 0;
    ack_force = 1'b0;
    rd_xor   = '0;
    rst_n    = 1'b0;
    bus.ram_read  = 1'b0;
    bus.ram_write = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;

    step();
    step();
    check("rst_ext_req",   bus.ext_req,   0);
    check("rst_mem_busy",  bus.mem_busy,  0);
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_d_rdata",   bus.d_rdata,   16'h0000);
    check("rst_if_rdata",  bus.if_rdata,  16'h0000);
    check("rst_ext_addr",  bus.ext_addr,  16'h0000);
    check("rst_bus_err",   bus.bus_err,   0);
    rst_n = 1'b1;
    step();

    // Read, ack in the third request cycle
    ack_wait = 2;
    rd_xor   = 16'hBEAF;
    bus.ram_read = 1'b1;
    bus.d_addr   = 16'h0040;
    step();
    bus.ram_read = 1'b0;
    busy_n = 0; got = 1'b0; a = '0; w = 1'b0; wd = '0;
    for (int i = 0; i < 20 && !bus.mem_ready; i++) begin
      if (bus.mem_busy) busy_n++;
      if (bus.ext_req && !got) begin
        a = bus.ext_addr; w = bus.ext_we; wd = bus.ext_wdata; got = 1'b1;
      end
      step();
    end
    check("rd_ready",     bus.mem_ready, 1);
    check("rd_busy_cyc",  16'(busy_n),   16'd4);
    check("rd_data",      bus.d_rdata,   16'hBEEF);
    check("rd_ext_addr",  a,             16'h0040);
    check("rd_ext_we",    w,             0);
    check("rd_ext_wdata", wd,            16'h0000);
    check("rd_done_busy", bus.mem_busy,  0);
    check("rd_done_req",  bus.ext_req,   0);
    step();
    check("rd_ready_pulse", bus.mem_ready, 0);
    check("rd_data_hold",   bus.d_rdata,   16'hBEEF);

    // Write, immediate ack
    ack_wait = 0;
    bus.ram_write = 1'b1;
    bus.d_addr    = 16'h0010;
    bus.d_wdata   = 16'h1234;
    step();
    bus.ram_write = 1'b0;
    req_n = 0; ready_seen = 1'b0; a = '0; w = 1'b0; wd = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ext_req) begin
        req_n++; a = bus.ext_addr; w = bus.ext_we; wd = bus.ext_wdata;
      end
      if (bus.mem_ready) ready_seen = 1'b1;
      step();
    end
    check("wr_req_cyc",  16'(req_n),    16'd1);
    check("wr_ext_we",   w,             1);
    check("wr_ext_addr", a,             16'h0010);
    check("wr_wdata",    wd,            16'h1234);
    check("wr_no_ready", ready_seen,    0);
    check("wr_busy_end", bus.mem_busy,  0);
    check("wr_we_end",   bus.ext_we,    0);

    // Fetch vs data contention after a data grant
    ack_wait = 1;
    rd_xor   = 16'hA5A5;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0200;
    bus.ram_read = 1'b1;
    bus.d_addr   = 16'h0300;
    step();
    bus.ram_read = 1'b0;
    gn = 0; g0 = '0; g1 = '0; ifd = '0; prev_req = 1'b0; busy_low = 0;
    for (int i = 0; i < 30 && !bus.mem_ready; i++) begin
      if (bus.ext_req && !prev_req) begin
        if (gn == 0) g0 = bus.ext_addr;
        else g1 = bus.ext_addr;
        gn++;
      end
      prev_req = bus.ext_req;
      if (bus.if_ready) begin
        ifd = bus.if_rdata;
        bus.if_req = 1'b0;
      end
      if (!bus.mem_busy) busy_low++;
      step();
    end
    check("ct_ready",     bus.mem_ready,  1);
    check("ct_grants",    16'(gn),        16'd2);
    check("ct_first",     g0,             16'h0200);
    check("ct_second",    g1,             16'h0300);
    check("ct_if_rdata",  ifd,            16'hA7A5);
    check("ct_d_rdata",   bus.d_rdata,    16'hA6A5);
    check("ct_busy_low",  16'(busy_low),  16'd0);
    step();

    // Read and write together behave as a write
    ack_wait = 0;
    bus.ram_read  = 1'b1;
    bus.ram_write = 1'b1;
    bus.d_addr    = 16'h0077;
    bus.d_wdata   = 16'h5555;
    step();
    bus.ram_read  = 1'b0;
    bus.ram_write = 1'b0;
    we_seen = 1'b0; ready_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ext_req && bus.ext_we) we_seen = 1'b1;
      if (bus.mem_ready) ready_seen = 1'b1;
      step();
    end
    check("rw_is_write", we_seen,    1);
    check("rw_no_ready", ready_seen, 0);

    // Fetch survives if_req dropping mid-access
    ack_wait = 3;
    rd_xor   = 16'h1111;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0ABC;
    step();
    bus.if_req = 1'b0;
    for (int i = 0; i < 20 && !bus.if_ready; i++) step();
    check("fe_ready",  bus.if_ready, 1);
    check("fe_rdata",  bus.if_rdata, 16'h1BAD);
    check("fe_req",    bus.ext_req,  0);
    step();
    check("fe_pulse",  bus.if_ready, 0);

    // Reset in the middle of a data read
    ack_wait = 100;
    rd_xor   = '0;
    bus.ram_read = 1'b1;
    bus.d_addr   = 16'h0123;
    step();
    bus.ram_read = 1'b0;
    for (int i = 0; i < 10 && !bus.ext_req; i++) step();
    check("mr_in_access", bus.ext_req, 1);
    rst_n = 1'b0;
    #1;
    check("mr_req_drop",  bus.ext_req,  0);
    check("mr_busy_drop", bus.mem_busy, 0);
    check("mr_addr_clr",  bus.ext_addr, 16'h0000);
    check("mr_rdata_clr", bus.d_rdata,  16'h0000);
    ack_force = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("mr_late_req",   bus.ext_req,   0);
    check("mr_late_ready", bus.mem_ready, 0);
    check("mr_late_busy",  bus.mem_busy,  0);
    check("mr_late_data",  bus.d_rdata,   16'h0000);
    ack_force = 1'b0;
    ack_wait  = 0;
    rd_xor    = 16'h4444;
    bus.ram_read = 1'b1;
    bus.d_addr   = 16'h0321;
    step();
    bus.ram_read = 1'b0;
    for (int i = 0; i < 20 && !bus.mem_ready; i++) step();
    check("mr_next_ready", bus.mem_ready, 1);
    check("mr_next_data",  bus.d_rdata,   16'h4765);
    step();

`ifdef MEM_TIMEOUT_EN
    ack_wait = 100000;
    bus.ram_read = 1'b1;
    bus.d_addr   = 16'h0055;
    step();
    bus.ram_read = 1'b0;
    for (int i = 0; i < 400 && !bus.bus_err; i++) step();
    check("to_bus_err", bus.bus_err,   1);
    check("to_ready",   bus.mem_ready, 1);
    check("to_rdata",   bus.d_rdata,   16'hFFFF);
    step();
    check("to_err_pulse", bus.bus_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
